// File: rtl/prog_loader.sv
// prog_loader
//
// Loads a framed program image into the CPU's instruction memory. The input
// is a stream of 16-bit halfwords on a valid/ready handshake:
//   header N (word count), then 2N payload halfwords (high half first),
//   then one checksum halfword (XOR of all payload halfwords).
// Pairs of payload halfwords become 32-bit words that are written to the
// instruction memory at addresses 0..N-1. The CPU is held in reset
// throughout a load and is released only after a matching checksum.
//
// Ports:
//   clk_i          system clock, all state on the rising edge
//   sys_rest_i     asynchronous active-high reset
//   start_i        single-cycle pulse, begins a load from IDLE/DONE/ERR
//   din_i          program stream halfword
//   din_valid_i    din_i carries a halfword
//   din_ready_o    loader accepts din_i this cycle (state decode only)
//   imem_we_o      instruction memory write strobe, one cycle per word
//   imem_addr_o    instruction memory write address
//   imem_wdata_o   instruction word to write
//   cpu_rest_o     reset to the CPU core, 1 = held in reset
//   busy_o         load in progress
//   done_o         last load completed with a good checksum
//   err_o          last load failed (bad length or checksum)
//
// States:
//   IDLE | waiting for the first start after reset
//   HDR  | expecting the header halfword (word count N)
//   HI   | expecting the high half of the current word
//   LO   | expecting the low half; the word is written on this transfer
//   CHK  | expecting the checksum halfword
//   DONE | load good, CPU released
//   ERR  | load failed, CPU held in reset

module prog_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          sys_rest_i,
    input  logic          start_i,
    input  logic [15:0]   din_i,
    input  logic          din_valid_i,
    output logic          din_ready_o,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic          cpu_rest_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_HW = 16'(DEPTH);
    localparam logic [AW:0] ONE_IDX  = {{AW{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    // Word count and index are one bit wider than the address so that a
    // full-depth load (N = DEPTH) is representable and never wraps.
    logic [AW:0]   n_q, n_d;
    logic [AW:0]   idx_q, idx_d;
    logic [15:0]   upper_q, upper_d;
    logic [15:0]   acc_q, acc_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          in_load;
    logic          xfer;

    // Ready is a pure decode of the state register, so there is no
    // combinational path from din_valid_i to din_ready_o.
    assign in_load = (state_q == S_HDR) || (state_q == S_HI) ||
                     (state_q == S_LO)  || (state_q == S_CHK);
    assign xfer    = in_load & din_valid_i;

    always_ff @(posedge clk_i or posedge sys_rest_i) begin
        if (sys_rest_i) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            upper_q <= '0;
            acc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            upper_q <= upper_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        upper_d = upper_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_HDR;
            end
            S_HDR: begin
                if (xfer) begin
                    if ((din_i != 16'd0) && (din_i <= DEPTH_HW)) begin
                        n_d     = din_i[AW:0];
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = S_HI;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    upper_d = din_i;
                    acc_d   = acc_q ^ din_i;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    acc_d   = acc_q ^ din_i;
                    we_d    = 1'b1;
                    addr_d  = idx_q[AW-1:0];
                    wdata_d = {upper_q, din_i};
                    if (idx_q == (n_q - ONE_IDX)) begin
                        state_d = S_CHK;
                    end else begin
                        idx_d   = idx_q + ONE_IDX;
                        state_d = S_HI;
                    end
                end
            end
            S_CHK: begin
                if (xfer) begin
                    if (din_i == acc_q) state_d = S_DONE;
                    else                state_d = S_ERR;
                end
            end
            S_DONE: begin
                if (start_i) state_d = S_HDR;
            end
            S_ERR: begin
                if (start_i) state_d = S_HDR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign din_ready_o  = in_load;
    assign busy_o       = in_load;
    assign done_o       = (state_q == S_DONE);
    assign err_o        = (state_q == S_ERR);
    assign cpu_rest_o   = (state_q != S_DONE);
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        clk;
    logic        clk_en;
    logic        sys_rest;
    logic        start;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rest;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader #(.DEPTH(16), .AW(4)) dut (
        .clk_i        (clk),
        .sys_rest_i   (sys_rest),
        .start_i      (start),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .din_ready_o  (din_ready),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .cpu_rest_o   (cpu_rest),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Expected events: 0 = memory write, 1 = load done, 2 = load error
    typedef struct {
        int          kind;
        logic [3:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          passed;
    int          total;
    logic [31:0] frame_w [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic push_ev(input int kind, input logic [3:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or finishes a load.
    logic done_p, err_p;
    always @(negedge clk) begin
        if (sys_rest) begin
            done_p = 1'b0;
            err_p  = 1'b0;
        end else begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {28'd0, imem_addr}, 32'hFFFFFFFF);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("write_kind", 32'(0), 32'(e.kind));
                    chk("write_addr", {28'd0, imem_addr}, {28'd0, e.addr});
                    chk("write_data", imem_wdata, e.data);
                end
            end
            if ((done && !done_p) || (err && !err_p)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_outcome", {30'd0, err, done}, 32'hFFFFFFFF);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("outcome_kind", done ? 32'd1 : 32'd2, 32'(e.kind));
                end
            end
            done_p = done;
            err_p  = err;
        end
    end

    // Sends one halfword; inputs are changed 1 time unit after a rising edge.
    task automatic send(input logic [15:0] d, input int gapmax, output int edges);
        int g;
        int bound;
        edges = 0;
        g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        din_valid = 1'b0;
        repeat (g) begin
            @(posedge clk); #1;
            edges++;
        end
        din = d;
        din_valid = 1'b1;
        bound = 0;
        while (!din_ready && bound < 100) begin
            @(posedge clk); #1;
            edges++;
            bound++;
        end
        if (!din_ready) chk("ready_timeout", 32'(bound), 32'd0);
        @(posedge clk); #1;
        edges++;
        din_valid = 1'b0;
    endtask

    // Reference model of a whole load: frame words come from frame_w, the
    // trailer is the payload XOR with mask applied. abort_after > 0 stops
    // after that many payload halfwords.
    task automatic load(input logic [15:0] hdr, input logic [15:0] mask,
                        input int gapmax, input int abort_after, output int edges);
        int          e;
        int          sent;
        logic [15:0] acc;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] trailer;
        edges = 0;
        sent  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges++;
        chk("start_cpu_rest", {31'd0, cpu_rest}, 32'd1);
        chk("start_busy", {31'd0, busy}, 32'd1);
        if (hdr == 16'd0 || hdr > 16'd16) begin
            push_ev(2, 4'd0, 32'd0);
            send(hdr, gapmax, e);
            edges += e;
            return;
        end
        send(hdr, gapmax, e);
        edges += e;
        acc = 16'd0;
        for (int i = 0; i < int'(hdr); i++) begin
            hi = frame_w[i][31:16];
            lo = frame_w[i][15:0];
            acc = acc ^ hi ^ lo;
            send(hi, gapmax, e);
            edges += e;
            sent++;
            if (abort_after > 0 && sent >= abort_after) return;
            push_ev(0, 4'(i), frame_w[i]);
            send(lo, gapmax, e);
            edges += e;
            sent++;
            if (abort_after > 0 && sent >= abort_after) return;
        end
        trailer = acc ^ mask;
        push_ev((trailer == acc) ? 1 : 2, 4'd0, 32'd0);
        send(trailer, gapmax, e);
        edges += e;
    endtask

    int          edges;
    logic [15:0] hdr;
    logic [15:0] mask;
    bit          exp_done;

    initial begin
        passed    = 0;
        total     = 0;
        clk_en    = 1'b0;
        sys_rest  = 1'b0;
        start     = 1'b0;
        din       = 16'd0;
        din_valid = 1'b0;

        // Reset with the clock stopped
        #5 sys_rest = 1'b1;
        #1;
        chk("rst_din_ready", {31'd0, din_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", {28'd0, imem_addr}, 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rest", {31'd0, cpu_rest}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 sys_rest = 1'b0;
        @(posedge clk); #1;

        // Good load from the reference frame
        frame_w[0] = 32'h08000005;
        frame_w[1] = 32'h08410006;
        load(16'd2, 16'h0000, 0, 0, edges);
        chk("good_latency", 32'(edges), 32'd7);
        chk("good_done", {31'd0, done}, 32'd1);
        chk("good_cpu_rest", {31'd0, cpu_rest}, 32'd0);
        chk("good_busy", {31'd0, busy}, 32'd0);
        chk("good_ready", {31'd0, din_ready}, 32'd0);

        // Bad checksum (trailer 0x0043), then a retry with the good frame
        load(16'd2, 16'h0001, 0, 0, edges);
        chk("badsum_err", {31'd0, err}, 32'd1);
        chk("badsum_done", {31'd0, done}, 32'd0);
        chk("badsum_cpu_rest", {31'd0, cpu_rest}, 32'd1);
        load(16'd2, 16'h0000, 0, 0, edges);
        chk("retry_done", {31'd0, done}, 32'd1);

        // Bad lengths
        load(16'h0000, 16'h0000, 0, 0, edges);
        chk("len0_err", {31'd0, err}, 32'd1);
        chk("len0_ready", {31'd0, din_ready}, 32'd0);
        load(16'h0011, 16'h0000, 0, 0, edges);
        chk("len17_err", {31'd0, err}, 32'd1);
        chk("len17_ready", {31'd0, din_ready}, 32'd0);
        chk("len17_busy", {31'd0, busy}, 32'd0);

        // Full depth with valid gaps
        for (int i = 0; i < 16; i++) frame_w[i] = $urandom;
        load(16'd16, 16'h0000, 3, 0, edges);
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_cpu_rest", {31'd0, cpu_rest}, 32'd0);

        // Random frames
        for (int k = 0; k < 10; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      hdr = 16'd0;
            else if (r == 1) hdr = 16'(17 + $urandom_range(0, 60000));
            else             hdr = 16'($urandom_range(1, 16));
            mask = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0;
            for (int i = 0; i < 16; i++) frame_w[i] = $urandom;
            load(hdr, mask, 2, 0, edges);
            exp_done = (hdr >= 16'd1) && (hdr <= 16'd16) && (mask == 16'd0);
            chk("rand_done", {31'd0, done}, {31'd0, exp_done});
            chk("rand_err", {31'd0, err}, {31'd0, !exp_done});
        end

        // Reset in the middle of a load, after the third payload halfword
        for (int i = 0; i < 16; i++) frame_w[i] = $urandom;
        load(16'd4, 16'h0000, 0, 3, edges);
        #2 sys_rest = 1'b1;
        #1;
        chk("midrst_cpu_rest", {31'd0, cpu_rest}, 32'd1);
        chk("midrst_ready", {31'd0, din_ready}, 32'd0);
        chk("midrst_we", {31'd0, imem_we}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 sys_rest = 1'b0;
        @(posedge clk); #1;
        chk("midrst_idle_ready", {31'd0, din_ready}, 32'd0);
        frame_w[0] = 32'h08000005;
        frame_w[1] = 32'h08410006;
        load(16'd2, 16'h0000, 0, 0, edges);
        chk("midrst_reload_done", {31'd0, done}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
